seq_pattern_counter: RTL and testbench
======================================

Name: seq_pattern_counter

Overview:
Parametrised serial pattern detector and occurrence counter, successor to the fixed 3-bit "abb" Moore counter.
- Pattern, pattern length, count width and overlap mode are parameters.
- Adds an input qualifier, a synchronous count clear, a registered detect pulse and a sticky overflow flag.
- Sits on a 1-bit serial stream. Feeds status and count registers.

Parameters:
PAT_LEN, 3, pattern length in bits; legal 2..16
PATTERN, 3'b011, target sequence; MSB is the earliest-received bit (a=0, b=1, so "abb" = 011)
CNT_W, 4, width of occurrence counter; legal 1..32
OVERLAP, 1, 1 = overlapping matches counted; 0 = history discarded after each match

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
en  input  1  bit-valid qualifier; ip is sampled only when en=1
ip  input  1  serial data bit
clr  input  1  synchronous clear of cn_out and ovf
det  output  1  registered one-cycle match pulse
cn_out  output  CNT_W  number of matches since reset/clr
ovf  output  1  sticky; set when an increment is attempted with cn_out at all-ones

Behaviour:
- Reset (reset=1 at edge) overrides all other inputs. It clears:
  - hist (PAT_LEN-bit shift register)
  - fill (clog2(PAT_LEN+1) bits)
  - det=0, cn_out=0, ovf=0
- Accepted bit: an edge with en=1 and reset=0.
  - hist <= {hist[PAT_LEN-2:0], ip}.
  - fill increments and saturates at PAT_LEN.
- Match condition at an accepted bit: the new hist value equals PATTERN, and fill (including this bit) reaches PAT_LEN. Leading reset zeros never match, e.g. PATTERN=000 needs three real zeros.
- Moore output: det is high for exactly one cycle after the edge that accepted the matching bit. det=0 on every edge with en=0.
- cn_out increments on the same edge that sets det, so the latency from the last pattern bit to det/cn_out is 1 edge.
- OVERLAP=1: hist and fill continue after a match, so a pattern suffix can start the next match.
- OVERLAP=0: after a match, fill <= 0 and hist <= 0. The next match needs PAT_LEN fresh bits.
- en=0: hist, fill and cn_out hold. det=0.
- clr=1 (reset=0): cn_out <= 0 and ovf <= 0.
  - hist, fill and det are unaffected; det still pulses on a simultaneous match.
  - clr wins over a simultaneous increment.
- Overflow: a match while cn_out is all-ones sets ovf=1. ovf stays set until reset or clr. cn_out handling depends on CNT_SAT_EN (see below).
- Reset mid-sequence discards the partial history. Bits accepted before reset never contribute to a match.

Optional Feature:
CNT_SAT_EN
- Defined: cn_out saturates at all-ones; further matches still pulse det and keep ovf=1.
- Undefined: cn_out wraps modulo 2^CNT_W, all-ones to 0. ovf is set on the wrapping increment.

Test Plan:
1. Defaults, en=1, ip=0,1,1 after reset -> det=1 in the cycle after the 3rd bit; cn_out=1. Stream 0,1,1,0,1,1,1 -> cn_out=2, det high exactly twice.
2. PAT_LEN=3, PATTERN=101, stream 1,0,1,0,1:
   - OVERLAP=1 -> cn_out=2, det after bits 3 and 5
   - OVERLAP=0 -> cn_out=1
3. Defaults, en gating: ip=0(en=1), 1(en=0), 1(en=1), 1(en=1) -> bit with en=0 ignored; match on 4th bit; cn_out=1. With en=0 for 5 cycles, cn_out and det are unchanged.
4. CNT_W=2, defaults, 4 matches:
   - without CNT_SAT_EN -> cn_out=0, ovf=1
   - with CNT_SAT_EN -> cn_out=3, ovf=1
   - then clr=1 for one cycle -> cn_out=0, ovf=0
5. Reset mid-operation: ip=0,1, then reset=1 for one cycle, then ip=1 -> no det, cn_out=0. Then 0,1,1 -> cn_out=1.
6. PATTERN=000, PAT_LEN=3: two zeros after reset -> no det; a third zero -> det, cn_out=1. clr asserted on the same edge as a match -> det=1, cn_out=0.

Source files
------------

// File: rtl/seq_pattern_counter.sv
// seq_pattern_counter
// -------------------
// Serial pattern detector and occurrence counter on a 1-bit stream.
//
// Parameters:
//   PAT_LEN - pattern length in bits (2..16)
//   PATTERN - target sequence, MSB is the earliest-received bit
//   CNT_W   - occurrence counter width (1..32)
//   OVERLAP - 1: overlapping matches count; 0: history discarded after a match
//
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous active-high reset, overrides everything
//   en     - bit-valid qualifier; ip is accepted only when en=1
//   ip     - serial data bit
//   clr    - synchronous clear of cn_out and ovf
//   det    - registered one-cycle match pulse
//   cn_out - matches since reset/clr
//   ovf    - sticky overflow, set on an increment attempted at all-ones
//
// Handshake: there is no back-pressure. A bit is transferred on every rising
// edge where en=1 and reset=0; with en=0 the stream state simply holds.
//
// Configuration macro: CNT_SAT_EN
//   defined   - cn_out saturates at all-ones
//   undefined - cn_out wraps modulo 2^CNT_W
module seq_pattern_counter #(
  parameter int               PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b011,
  parameter int               CNT_W   = 4,
  parameter int               OVERLAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ip,
  input  logic             clr,
  output logic             det,
  output logic [CNT_W-1:0] cn_out,
  output logic             ovf
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [PAT_LEN-1:0] hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  always_comb begin
    hist_shift = {hist_q[PAT_LEN-2:0], ip};
    // fill counts real bits so leading reset zeros never form a match
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match      = en && (hist_shift == PATTERN) && (fill_inc == FILL_FULL);

    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    if (en) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
    end

    if (match) begin
      det_d = 1'b1;
      if (OVERLAP == 0) begin
        hist_d = '0;
        fill_d = '0;
      end
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
`ifdef CNT_SAT_EN
        cnt_d = cnt_q;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // clr beats a simultaneous increment but leaves det/history alone
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign det    = det_q;
  assign cn_out = cnt_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Testbench for seq_pattern_counter. Five instances with different parameter
// sets share one stimulus stream; a reference model keeps the raw accepted
// bit stream and a per-instance match tally.
module tb_seq_pattern_counter;

  localparam int NI = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, en, ip, clr;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       det0, det1, det2, det3, det4;
  logic [3:0] cn0, cn1, cn2, cn4;
  logic [1:0] cn3;
  logic       ovf0, ovf1, ovf2, ovf3, ovf4;

  seq_pattern_counter #(.PAT_LEN(3), .PATTERN(3'b011), .CNT_W(4), .OVERLAP(1)) u0 (
    .clk(clk), .reset(reset), .en(en), .ip(ip), .clr(clr), .det(det0), .cn_out(cn0), .ovf(ovf0));
  seq_pattern_counter #(.PAT_LEN(3), .PATTERN(3'b101), .CNT_W(4), .OVERLAP(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .ip(ip), .clr(clr), .det(det1), .cn_out(cn1), .ovf(ovf1));
  seq_pattern_counter #(.PAT_LEN(3), .PATTERN(3'b101), .CNT_W(4), .OVERLAP(0)) u2 (
    .clk(clk), .reset(reset), .en(en), .ip(ip), .clr(clr), .det(det2), .cn_out(cn2), .ovf(ovf2));
  seq_pattern_counter #(.PAT_LEN(3), .PATTERN(3'b011), .CNT_W(2), .OVERLAP(1)) u3 (
    .clk(clk), .reset(reset), .en(en), .ip(ip), .clr(clr), .det(det3), .cn_out(cn3), .ovf(ovf3));
  seq_pattern_counter #(.PAT_LEN(3), .PATTERN(3'b000), .CNT_W(4), .OVERLAP(1)) u4 (
    .clk(clk), .reset(reset), .en(en), .ip(ip), .clr(clr), .det(det4), .cn_out(cn4), .ovf(ovf4));

  logic [NI-1:0] obs_det, obs_ovf;
  logic [31:0]   obs_cn [NI];
  assign obs_det = {det4, det3, det2, det1, det0};
  assign obs_ovf = {ovf4, ovf3, ovf2, ovf1, ovf0};
  assign obs_cn[0] = 32'(cn0);
  assign obs_cn[1] = 32'(cn1);
  assign obs_cn[2] = 32'(cn2);
  assign obs_cn[3] = 32'(cn3);
  assign obs_cn[4] = 32'(cn4);

  // ---------------- reference model ----------------
  int pat_v [NI] = '{3, 5, 5, 3, 0};
  int cw    [NI] = '{4, 4, 4, 2, 4};
  int ov    [NI] = '{1, 1, 0, 1, 1};
  localparam int PL = 3;

  bit stream[$];          // every bit accepted since the last reset
  int seg_start [NI];     // first stream index still usable for a match
  int mcount    [NI];     // matches since reset/clr (unbounded)
  bit exp_det   [NI];

  int n_vec  = 0;
  int n_miss = 0;

  function automatic bit model_match(int k);
    int n = stream.size();
    if (n - seg_start[k] < PL) return 1'b0;
    for (int i = 0; i < PL; i++)
      if (int'(stream[n - PL + i]) != ((pat_v[k] >> (PL - 1 - i)) & 1)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_cn(int k);
    int mx = (1 << cw[k]) - 1;
`ifdef CNT_SAT_EN
    return (mcount[k] > mx) ? mx : mcount[k];
`else
    return mcount[k] % (mx + 1);
`endif
  endfunction

  function automatic bit exp_ovf(int k);
    return mcount[k] > ((1 << cw[k]) - 1);
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input bit r, input bit e, input bit b, input bit c);
    reset = r; en = e; ip = b; clr = c;
    @(posedge clk);
    if (r) begin
      stream.delete();
      for (int k = 0; k < NI; k++) begin
        seg_start[k] = 0; mcount[k] = 0; exp_det[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) exp_det[k] = 1'b0;
      if (e) begin
        stream.push_back(b);
        for (int k = 0; k < NI; k++) begin
          if (model_match(k)) begin
            exp_det[k] = 1'b1;
            mcount[k]++;
            if (ov[k] == 0) seg_start[k] = stream.size();
          end
        end
      end
      if (c) for (int k = 0; k < NI; k++) mcount[k] = 0;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply(1, 0, 0, 0);
    apply(1, 1, 1, 0);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if (obs_det[k] !== 1'b0 || obs_cn[k] !== 32'd0 || obs_ovf[k] !== 1'b0) begin
        n_miss++;
        $display("FAIL reset u%0d: det=%b cn=%0d ovf=%b, want 0/0/0", k, obs_det[k], obs_cn[k], obs_ovf[k]);
      end
    end
  endtask

  task automatic test_basic();
    bit s[7] = '{0, 1, 1, 0, 1, 1, 1};
    int pulses = 0;
    apply(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      apply(0, 1, s[i], 0);
      if (det0) pulses++;
      for (int k = 0; k < NI; k++) begin
        n_vec++;
        if (obs_det[k] !== exp_det[k] || obs_cn[k] !== 32'(exp_cn(k)) || obs_ovf[k] !== exp_ovf(k)) begin
          n_miss++;
          $display("FAIL basic u%0d step %0d: det=%b cn=%0d ovf=%b, want %b/%0d/%b",
                   k, i, obs_det[k], obs_cn[k], obs_ovf[k], exp_det[k], exp_cn(k), exp_ovf(k));
        end
      end
      if (i == 2) begin
        n_vec++;
        if (det0 !== 1'b1 || cn0 !== 4'd1) begin
          n_miss++; $display("FAIL basic_first: det=%b cn=%0d, want 1/1", det0, cn0);
        end
      end
    end
    n_vec++;
    if (cn0 !== 4'd2 || pulses != 2) begin
      n_miss++; $display("FAIL basic_total: cn=%0d pulses=%0d, want 2/2", cn0, pulses);
    end
  endtask

  task automatic test_overlap();
    bit s[5] = '{1, 0, 1, 0, 1};
    bit d1[5] = '{0, 0, 1, 0, 1};
    apply(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, s[i], 0);
      n_vec++;
      if (det1 !== d1[i]) begin
        n_miss++; $display("FAIL overlap_det step %0d: got %b want %b", i, det1, d1[i]);
      end
    end
    n_vec++;
    if (cn1 !== 4'd2 || cn2 !== 4'd1) begin
      n_miss++; $display("FAIL overlap_count: ov1=%0d ov0=%0d, want 2/1", cn1, cn2);
    end
  endtask

  task automatic test_en_gating();
    bit e[4] = '{1, 0, 1, 1};
    bit b[4] = '{0, 1, 1, 1};
    apply(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(0, e[i], b[i], 0);
      n_vec++;
      if (det0 !== (i == 3) || det0 !== exp_det[0]) begin
        n_miss++; $display("FAIL en_det step %0d: got %b want %b", i, det0, (i == 3));
      end
    end
    n_vec++;
    if (cn0 !== 4'd1) begin
      n_miss++; $display("FAIL en_count: got %0d want 1", cn0);
    end
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1'($urandom_range(0, 1)), 0);
      n_vec++;
      if (det0 !== 1'b0 || cn0 !== 4'd1) begin
        n_miss++; $display("FAIL en_hold: det=%b cn=%0d, want 0/1", det0, cn0);
      end
    end
  endtask

  task automatic test_overflow();
    apply(1, 0, 0, 0);
    for (int m = 0; m < 4; m++) begin
      apply(0, 1, 0, 0);
      apply(0, 1, 1, 0);
      apply(0, 1, 1, 0);
    end
    n_vec++;
`ifdef CNT_SAT_EN
    if (cn3 !== 2'd3 || ovf3 !== 1'b1) begin
      n_miss++; $display("FAIL ovf_sat: cn=%0d ovf=%b, want 3/1", cn3, ovf3);
    end
`else
    if (cn3 !== 2'd0 || ovf3 !== 1'b1) begin
      n_miss++; $display("FAIL ovf_wrap: cn=%0d ovf=%b, want 0/1", cn3, ovf3);
    end
`endif
    n_vec++;
    if (ovf0 !== 1'b0 || cn0 !== 4'd4) begin
      n_miss++; $display("FAIL ovf_wide: cn=%0d ovf=%b, want 4/0", cn0, ovf0);
    end
    apply(0, 0, 0, 1);
    n_vec++;
    if (cn3 !== 2'd0 || ovf3 !== 1'b0) begin
      n_miss++; $display("FAIL ovf_clr: cn=%0d ovf=%b, want 0/0", cn3, ovf3);
    end
  endtask

  task automatic test_reset_mid();
    apply(1, 0, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 1, 1, 0);
    apply(1, 1, 1, 0);
    apply(0, 1, 1, 0);
    n_vec++;
    if (det0 !== 1'b0 || cn0 !== 4'd0) begin
      n_miss++; $display("FAIL reset_mid: det=%b cn=%0d, want 0/0", det0, cn0);
    end
    apply(0, 1, 0, 0);
    apply(0, 1, 1, 0);
    apply(0, 1, 1, 0);
    n_vec++;
    if (det0 !== 1'b1 || cn0 !== 4'd1) begin
      n_miss++; $display("FAIL reset_resume: det=%b cn=%0d, want 1/1", det0, cn0);
    end
  endtask

  task automatic test_zero_pattern();
    apply(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 0, 0);
      n_vec++;
      if (det4 !== 1'b0) begin
        n_miss++; $display("FAIL zero_early step %0d: det=%b want 0", i, det4);
      end
    end
    apply(0, 1, 0, 0);
    n_vec++;
    if (det4 !== 1'b1 || cn4 !== 4'd1) begin
      n_miss++; $display("FAIL zero_match: det=%b cn=%0d, want 1/1", det4, cn4);
    end
    apply(0, 1, 0, 1);
    n_vec++;
    if (det4 !== 1'b1 || cn4 !== 4'd0 || ovf4 !== 1'b0) begin
      n_miss++; $display("FAIL zero_clr: det=%b cn=%0d ovf=%b, want 1/0/0", det4, cn4, ovf4);
    end
  endtask

  task automatic test_random();
    apply(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
            1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
      for (int k = 0; k < NI; k++) begin
        n_vec++;
        if (obs_det[k] !== exp_det[k] || obs_cn[k] !== 32'(exp_cn(k)) || obs_ovf[k] !== exp_ovf(k)) begin
          n_miss++;
          $display("FAIL random u%0d cycle %0d: det=%b cn=%0d ovf=%b, want %b/%0d/%b",
                   k, i, obs_det[k], obs_cn[k], obs_ovf[k], exp_det[k], exp_cn(k), exp_ovf(k));
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; en = 1'b0; ip = 1'b0; clr = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_en_gating();
    test_overflow();
    test_reset_mid();
    test_zero_pattern();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
